// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;
    localparam int BYTE_W = 8;
    localparam int LEN_W = 16;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian bytes into words and pulses word_valid once per word.
module imem_word_packer
    import imem_boot_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              last,
    output logic [W-1:0]      word,
    output logic              word_valid
);
    localparam int NB = W / BYTE_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    logic [CW-1:0]       cnt;
    logic [W-BYTE_W-1:0] asm_q;
    assign last = cnt == CW'(NB - 1);
    // word only changes on completion so it stays stable while the next word streams in
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            asm_q      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && last;
            if (clr) begin
                cnt <= '0;
            end else if (byte_en) begin
                cnt   <= last ? '0 : cnt + CW'(1);
                asm_q <= (W-BYTE_W)'({byte_data, asm_q} >> BYTE_W);
                if (last) word <= {byte_data, asm_q};
            end
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte stream into instruction RAM, holding the core in reset meanwhile.
// Define IMEM_BOOT_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int           W           = 32,
    parameter int           DEPTH_WORDS = 2048,
    parameter logic [W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              run,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              is_write,
    output logic [W-1:0]      im_addr,
    output logic [W-1:0]      im_inst,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_written
);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif
    state_t             state, state_n;
    logic [BYTE_W-1:0]  len_lo;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               acc, data_acc, word_last, word_done, load_go;
    assign acc       = rx_valid && rx_ready;
    assign data_acc  = acc && state == S_DATA;
    assign word_done = data_acc && word_last;
    assign len_n     = {rx_data, len_lo};
    assign load_go   = state_n == S_LEN_LO && state != S_LEN_LO;
    imem_word_packer #(.W(W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_n == S_DATA && state != S_DATA),
        .byte_en    (data_acc),
        .byte_data  (rx_data),
        .last       (word_last),
        .word       (im_inst),
        .word_valid (is_write)
    );
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum;
    logic              chk_ok;
    assign chk_ok = BYTE_W'(sum + rx_data) == '0;
    always_ff @(posedge clk) begin
        if (rst || load_go) sum <= '0;
        else if (data_acc) sum <= sum + rx_data;
    end
`endif
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = start ? S_LEN_LO : run ? S_DONE : S_IDLE;
            S_LEN_LO: state_n = acc ? S_LEN_HI : S_LEN_LO;
            S_LEN_HI: if (acc) state_n = len_n == '0 ? S_FIN : int'(len_n) > DEPTH_WORDS ? S_ERR : S_DATA;
            S_DATA:   if (word_done && words_written == len_q - LEN_W'(1)) state_n = S_FIN;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            S_CHK:    if (acc) state_n = chk_ok ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: state_n = start ? S_LEN_LO : state;
            default:  state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rx_ready      <= 1'b0;
            busy          <= 1'b0;
            core_rst      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            im_addr       <= BASE_ADDR;
            len_lo        <= '0;
            len_q         <= '0;
        end else begin
            state    <= state_n;
            rx_ready <= state_n inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
            busy     <= state_n inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
            core_rst <= state_n != S_DONE;
            done     <= state_n == S_DONE;
            error    <= state_n == S_ERR;
            if (acc && state == S_LEN_LO) len_lo <= rx_data;
            if (acc && state == S_LEN_HI) len_q <= len_n;
            if (load_go) begin
                words_written <= '0;
                im_addr       <= BASE_ADDR;
            end else if (word_done) begin
                words_written <= words_written + LEN_W'(1);
                im_addr       <= BASE_ADDR + W'(words_written) * W'(WORD_BYTES);
            end
        end
    end
endmodule
